// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: pipeline control inputs, SRAM instruction-read handshake and IF/ID outputs.
// master = the fetch stage, slave = its environment (hazard unit, EXE, SRAM arbiter, decoder).
interface if_fetch_if;
  logic        if_PAUSE;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        mem_busy;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic [15:0] fi_INST;
  logic [15:0] fi_PC;
  logic        fi_VALID;

  modport master (
    input  if_PAUSE, jump_en, jump_addr, mem_busy, ram_ack, ram_rdata,
    output ram_req, ram_addr, fi_INST, fi_PC, fi_VALID
  );

  modport slave (
    output if_PAUSE, jump_en, jump_addr, mem_busy, ram_ack, ram_rdata,
    input  ram_req, ram_addr, fi_INST, fi_PC, fi_VALID
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch with IF/ID register: one word per cycle on a zero-wait SRAM, fi_* valid at the edge ending the request.
// Backpressure: if_PAUSE holds the outputs; one in-flight word is parked in a skid buffer and requests stop until it drains.
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input logic      clk_50MHz,
  input logic      rst,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] buf_inst;
  logic [15:0] buf_pc;
  logic        req;
  logic        fetch_done;

  assign pc_inc = pc + 16'd1;

  // State register
  always_ff @(posedge clk_50MHz) begin
    if (rst) state <= S_RESET;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.jump_en)                     state_nxt = S_FETCH;
        else if (fetch_done && bus.if_PAUSE) state_nxt = S_FULL;
      end
      S_FULL: begin
        if (bus.jump_en || !bus.if_PAUSE) state_nxt = S_FETCH;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // Output logic: a redirect or a busy MEM stage suppresses the request outright
  always_comb begin
    req        = (state == S_FETCH) && !bus.mem_busy && !bus.jump_en;
    fetch_done = req && bus.ram_ack;
  end

  assign bus.ram_req  = req;
  assign bus.ram_addr = pc;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (bus.jump_en && state != S_RESET) begin
      pc <= bus.jump_addr;
    end else if (fetch_done) begin
      pc <= pc_inc;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      buf_inst <= NOP_INST;
      buf_pc   <= RESET_PC;
    end else if (fetch_done && bus.if_PAUSE) begin
      buf_inst <= bus.ram_rdata;
      buf_pc   <= pc_inc;
    end
  end

  // IF/ID register; a redirect bubbles even while paused so the wrong-path word never reaches decode
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      bus.fi_INST  <= NOP_INST;
      bus.fi_PC    <= RESET_PC;
      bus.fi_VALID <= 1'b0;
    end else if (bus.jump_en) begin
      bus.fi_INST  <= NOP_INST;
      bus.fi_VALID <= 1'b0;
    end else if (bus.if_PAUSE) begin
      bus.fi_INST  <= bus.fi_INST;
      bus.fi_PC    <= bus.fi_PC;
      bus.fi_VALID <= bus.fi_VALID;
    end else if (state == S_FULL) begin
      bus.fi_INST  <= buf_inst;
      bus.fi_PC    <= buf_pc;
      bus.fi_VALID <= 1'b1;
    end else if (fetch_done) begin
      bus.fi_INST  <= bus.ram_rdata;
      bus.fi_PC    <= pc_inc;
      bus.fi_VALID <= 1'b1;
    end else begin
      bus.fi_INST  <= NOP_INST;
      bus.fi_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table for the listed corner cases, then random traffic against a behavioural model.
module tb_if_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic clk_50MHz = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  if_fetch_if bus_i ();

  if_fetch #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus_i.master)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic        rst;
    logic        pause;
    logic        jmp;
    logic [15:0] jaddr;
    logic        busy;
    logic        ack;
    logic [15:0] rdata;
    logic        chk_req;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
    logic        e_val;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic p, input logic j, input logic [15:0] ja,
                     input logic b, input logic a, input logic [15:0] rd,
                     input logic cr, input logic er, input logic [15:0] ea,
                     input logic [15:0] ei, input logic [15:0] ep, input logic ev);
    vec_t v;
    v = '{r, p, j, ja, b, a, rd, cr, er, ea, ei, ep, ev};
    tab.push_back(v);
  endtask

  task automatic drive(input logic r, input logic p, input logic j, input logic [15:0] ja,
                       input logic b, input logic a, input logic [15:0] rd);
    rst             = r;
    bus_i.if_PAUSE  = p;
    bus_i.jump_en   = j;
    bus_i.jump_addr = ja;
    bus_i.mem_busy  = b;
    bus_i.ram_ack   = a;
    bus_i.ram_rdata = rd;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA5C3;
  endfunction

  // Behavioural model state
  logic [15:0] m_pc, m_inst, m_opc;
  logic        m_val;
  bit          m_live;
  logic [15:0] m_q_inst[$];
  logic [15:0] m_q_pc[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    //   rst p  j  jaddr     b  a  rdata     cr er addr      inst      pc        v
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, NOP,      16'h0000, 0);
    add(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, NOP,      16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, NOP,      16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0001, 1);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0001, 1, 1, 16'h0001, 16'h0001, 16'h0002, 1);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 16'h0002, 16'h0002, 16'h0003, 1);
    // mem_busy for three cycles: acks offered but must be ignored
    add(0, 0, 0, 16'h0000, 1, 1, 16'h0003, 1, 0, 16'h0003, NOP,      16'h0003, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 16'h0003, 1, 0, 16'h0003, NOP,      16'h0003, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 16'h0003, 1, 0, 16'h0003, NOP,      16'h0003, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0003, 1, 1, 16'h0003, 16'h0003, 16'h0004, 1);
    // jump with simultaneous ack: data dropped
    add(0, 0, 1, 16'h0010, 0, 1, 16'h0004, 1, 0, 16'h0004, NOP,      16'h0004, 0);
    // pause on the ack of 0x0010
    add(0, 1, 0, 16'h0000, 0, 1, 16'h0010, 1, 1, 16'h0010, NOP,      16'h0004, 0);
    add(0, 1, 0, 16'h0000, 0, 1, 16'h0011, 1, 0, 16'h0011, NOP,      16'h0004, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0011, 1, 0, 16'h0011, 16'h0010, 16'h0011, 1);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0011, 1, 1, 16'h0011, 16'h0011, 16'h0012, 1);
    // two-cycle latency, jump during the wait
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0012, NOP,      16'h0012, 0);
    add(0, 0, 1, 16'h0100, 0, 1, 16'h0012, 1, 0, 16'h0012, NOP,      16'h0012, 0);
    add(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0100, NOP,      16'h0012, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0100, 1, 1, 16'h0100, 16'h0100, 16'h0101, 1);
    // wrap-around
    add(0, 0, 1, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 16'h0101, NOP,      16'h0101, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 1, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0001, 1);
    // fill the buffer, then jump while paused and full
    add(0, 1, 0, 16'h0000, 0, 1, 16'h0001, 1, 1, 16'h0001, 16'h0000, 16'h0001, 1);
    add(0, 1, 1, 16'h0200, 0, 0, 16'h0000, 1, 0, 16'h0002, NOP,      16'h0001, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0200, 1, 1, 16'h0200, 16'h0200, 16'h0201, 1);
    // rst and jump together: rst wins
    add(1, 0, 1, 16'h0300, 0, 1, 16'h0201, 1, 0, 16'h0201, NOP,      16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 0, 16'h0000, NOP,      16'h0000, 0);
    add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0001, 1);

    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk_50MHz);
      drive(tab[i].rst, tab[i].pause, tab[i].jmp, tab[i].jaddr, tab[i].busy, tab[i].ack, tab[i].rdata);
      #1;
      if (tab[i].chk_req) begin
        chk($sformatf("row%0d ram_req", i), {15'd0, bus_i.ram_req}, {15'd0, tab[i].e_req});
        chk($sformatf("row%0d ram_addr", i), bus_i.ram_addr, tab[i].e_addr);
      end
      @(posedge clk_50MHz);
      #1;
      chk($sformatf("row%0d fi_INST", i), bus_i.fi_INST, tab[i].e_inst);
      chk($sformatf("row%0d fi_PC", i), bus_i.fi_PC, tab[i].e_pc);
      chk($sformatf("row%0d fi_VALID", i), {15'd0, bus_i.fi_VALID}, {15'd0, tab[i].e_val});
    end

    // Random phase: model starts from a fresh reset
    @(negedge clk_50MHz);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    @(posedge clk_50MHz);
    m_pc = 16'h0000; m_inst = NOP; m_opc = 16'h0000; m_val = 1'b0; m_live = 1'b0;
    m_q_inst.delete(); m_q_pc.delete();

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r, p, j, b, a, e_req, done;
      logic [15:0] ja;
      r  = ($urandom_range(0, 99) < 2);
      p  = ($urandom_range(0, 99) < 30);
      j  = ($urandom_range(0, 99) < 10);
      b  = ($urandom_range(0, 99) < 20);
      a  = ($urandom_range(0, 99) < 60);
      ja = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ja = 16'hFFFF;
      @(negedge clk_50MHz);
      drive(r, p, j, ja, b, a, mem_word(m_pc));
      #1;
      e_req = m_live && (m_q_inst.size() == 0) && !b && !j;
      chk($sformatf("rnd%0d ram_req", cyc), {15'd0, bus_i.ram_req}, {15'd0, e_req});
      chk($sformatf("rnd%0d ram_addr", cyc), bus_i.ram_addr, m_pc);
      done = e_req && a;
      if (r) begin
        m_pc = 16'h0000; m_inst = NOP; m_opc = 16'h0000; m_val = 1'b0; m_live = 1'b0;
        m_q_inst.delete(); m_q_pc.delete();
      end else begin
        if (j) begin
          m_inst = NOP; m_val = 1'b0;
          m_q_inst.delete(); m_q_pc.delete();
        end else if (p) begin
          if (done) begin
            m_q_inst.push_back(mem_word(m_pc));
            m_q_pc.push_back(m_pc + 16'd1);
          end
        end else if (m_q_inst.size() != 0) begin
          m_inst = m_q_inst.pop_front(); m_opc = m_q_pc.pop_front(); m_val = 1'b1;
        end else if (done) begin
          m_inst = mem_word(m_pc); m_opc = m_pc + 16'd1; m_val = 1'b1;
        end else begin
          m_inst = NOP; m_val = 1'b0;
        end
        if (j && m_live)  m_pc = ja;
        else if (done)    m_pc = m_pc + 16'd1;
        m_live = 1'b1;
      end
      @(posedge clk_50MHz);
      #1;
      chk($sformatf("rnd%0d fi_INST", cyc), bus_i.fi_INST, m_inst);
      chk($sformatf("rnd%0d fi_PC", cyc), bus_i.fi_PC, m_opc);
      chk($sformatf("rnd%0d fi_VALID", cyc), {15'd0, bus_i.fi_VALID}, {15'd0, m_val});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
